common_memory: RTL and testbench
================================

// Module: common_memory
// PURPOSE
//   Unified single-port 512 x 32 data/instruction RAM for the RISC-V microcontroller.
//   The core or bus master issues one access per clock: a synchronous word write, or a
//   registered word read gated by an output enable.
//   Word-addressed only; no byte enables, no sub-word access.
// PARAMETERS
//   ADDR_W   9    address width; depth is 2**ADDR_W words (512), no out-of-range addresses
//   DATA_W   32   data word width
// PORTS
//   clk      in   1        system clock; all state updates on its rising edge
//   rst_n    in   1        asynchronous, active-low reset
//   Adr      in   ADDR_W   word address, shared by write and read
//   MWD      in   DATA_W   memory write data
//   MWR      in   1        memory write enable, active high
//   MOE      in   1        memory output enable (read request), active high
//   MRD      out  DATA_W   memory read data, registered
// BEHAVIOUR
//   Reset:
//   - rst_n low clears MRD to 0 and every storage word to 0 immediately, independent of clk.
//   - While rst_n is low, writes and reads are ignored.
//   - The first access is accepted on the first rising edge after rst_n goes high.
//   Write:
//   - At a rising edge with MWR=1, mem[Adr] <= MWD.
//   - The write is visible to a read on the next cycle.
//   Read:
//   - At a rising edge with MOE=1 and MWR=0, MRD <= mem[Adr].
//   - Read latency is 1 clock; MRD is valid after the edge and stable for the whole cycle.
//   Idle:
//   - At a rising edge with MOE=0, MRD <= 0. MRD never shows stale data when not enabled.
//   - MWR=0 and MOE=0 leaves memory contents unchanged.
//   Simultaneous MWR=1 and MOE=1:
//   - The write is performed.
//   - MRD <= MWD (write-first), so MRD shows the new data, never the old word.
//   Other rules:
//   - Writes to one address never disturb any other address.
//   - Rewriting an address overwrites it fully.
//   - Addresses 0 and 2**ADDR_W-1 behave like any other address; no wrap logic is needed.
//   - Inputs are sampled only at rising clk edges. Changes between edges have no effect.
//   - No X may propagate to MRD after reset for any address.
//   - Reset asserted mid-operation aborts any access in that cycle.
//   - After reset, all words read back 0 until rewritten.
// TESTING
//   1. Reset then read:
//      rst_n=0, then rst_n=1; MOE=1, MWR=0, Adr=10 -> MRD=0 one cycle later.
//   2. Write/readback with no aliasing:
//      write 32'h1 to Adr=10, then 32'h1 to Adr=0; read Adr=10 -> MRD=32'h1.
//      Then write 32'hDEADBEEF to Adr=0; read Adr=10 -> MRD=32'h1.
//   3. Boundary addresses:
//      write 32'hA5A5A5A5 to Adr=0 and 32'h5A5A5A5A to Adr=511.
//      Read each -> MRD matches the data written to that address.
//   4. Output enable and write-first:
//      MOE=0 after a read -> MRD=0 next cycle.
//      MWR=1, MOE=1, Adr=7, MWD=32'h12345678 -> MRD=32'h12345678 next cycle.
//      Then a plain read of Adr=7 -> MRD=32'h12345678.
//   5. Reset mid-operation:
//      fill Adr=3 with 32'hFFFFFFFF, assert rst_n=0 between edges -> MRD=0 immediately.
//      After release, read Adr=3 -> MRD=0.
//   6. Back-to-back access:
//      alternate write/read every cycle over random addresses, checked against a
//      scoreboard model -> every read matches with exactly 1-cycle latency.

Source files
------------

// File: rtl/common_memory_if.sv
// -----------------------------------------------------------------------------
// common_memory_if
//   Bus bundle for the unified 512 x 32 data/instruction RAM.
//   Signals:
//     Adr  word address, shared by write and read   (master -> slave)
//     MWD  write data                                (master -> slave)
//     MWR  write enable, active high                 (master -> slave)
//     MOE  output enable / read request, active high (master -> slave)
//     MRD  registered read data                      (slave  -> master)
//   Modports:
//     master  core / bus master side
//     slave   memory side
// -----------------------------------------------------------------------------
interface common_memory_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] Adr;
  logic [DATA_W-1:0] MWD;
  logic              MWR;
  logic              MOE;
  logic [DATA_W-1:0] MRD;

  modport master (
    output Adr,
    output MWD,
    output MWR,
    output MOE,
    input  MRD
  );

  modport slave (
    input  Adr,
    input  MWD,
    input  MWR,
    input  MOE,
    output MRD
  );
endinterface

// File: rtl/common_memory.sv
// -----------------------------------------------------------------------------
// common_memory
//   Unified single-port 2**ADDR_W x DATA_W RAM for the RISC-V microcontroller.
//   One access per clock: a synchronous word write and/or a registered word
//   read gated by the output enable. Word-addressed only.
//   Ports:
//     clk    system clock, all state updates on its rising edge
//     rst_n  asynchronous active-low reset; clears read data and every word
//     bus    common_memory_if.slave (Adr, MWD, MWR, MOE in; MRD out)
//   Read data is 0 whenever MOE was low at the previous edge. A simultaneous
//   write and read returns the new write data (write-first).
// -----------------------------------------------------------------------------
module common_memory #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  common_memory_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_p0;
  logic [DATA_W-1:0] w_rd_nxt;

  // Next read value: zero when not enabled, bypass write data on a
  // simultaneous write so the old word is never shown.
  always_comb begin
    w_rd_nxt = '0;
    if (bus.MOE) begin
      w_rd_nxt = bus.MWR ? bus.MWD : r_mem[bus.Adr];
    end
  end

  // Storage array: the whole array is cleared asynchronously so that every
  // word reads back 0 after reset until it is rewritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (bus.MWR) begin
      r_mem[bus.Adr] <= bus.MWD;
    end
  end

  // Read register stage (1-cycle latency)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_p0 <= '0;
    end else begin
      r_rd_p0 <= w_rd_nxt;
    end
  end

  assign bus.MRD = r_rd_p0;

endmodule

// File: tb/tb_common_memory.sv
module tb_common_memory;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  common_memory_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  common_memory #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference model: plain word array plus the read rules applied per access.
  logic [DATA_W-1:0] model_mem [DEPTH];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                          input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endtask

  // One clocked access; called just after an active edge, checks MRD 1ns
  // after the following edge against the model.
  task automatic access(input string tag, input logic we, input logic oe,
                        input logic [ADDR_W-1:0] adr, input logic [DATA_W-1:0] wd);
    logic [DATA_W-1:0] exp;
    bus.MWR = we;
    bus.MOE = oe;
    bus.Adr = adr;
    bus.MWD = wd;
    if (!oe)      exp = '0;
    else if (we)  exp = wd;
    else          exp = model_mem[adr];
    if (we) model_mem[adr] = wd;
    @(posedge clk);
    #1;
    check_eq(tag, bus.MRD, exp);
  endtask

  initial begin
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] last_a;
    logic [DATA_W-1:0] d;

    // Reset with a read request held active: reads are ignored in reset.
    rst_n   = 1'b0;
    bus.MWR = 1'b1;
    bus.MOE = 1'b1;
    bus.Adr = 10;
    bus.MWD = 32'hCAFEF00D;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_mrd", bus.MRD, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.MWR = 1'b0;
    bus.MOE = 1'b0;
    @(posedge clk);
    #1;

    // 1. Reset then read
    access("t1_read10_after_reset", 1'b0, 1'b1, 10, '0);
    access("t1_read0_after_reset",  1'b0, 1'b1, 0,  '0);

    // 2. No aliasing
    access("t2_wr10",    1'b1, 1'b0, 10, 32'h1);
    access("t2_wr0",     1'b1, 1'b0, 0,  32'h1);
    access("t2_rd10_a",  1'b0, 1'b1, 10, '0);
    access("t2_wr0_dead",1'b1, 1'b0, 0,  32'hDEADBEEF);
    access("t2_rd10_b",  1'b0, 1'b1, 10, '0);
    access("t2_rd0",     1'b0, 1'b1, 0,  '0);

    // 3. Boundary addresses
    access("t3_wr0",     1'b1, 1'b0, 0,   32'hA5A5A5A5);
    access("t3_wr511",   1'b1, 1'b0, 511, 32'h5A5A5A5A);
    access("t3_rd0",     1'b0, 1'b1, 0,   '0);
    access("t3_rd511",   1'b0, 1'b1, 511, '0);
    access("t3_rd510",   1'b0, 1'b1, 510, '0);

    // 4. Output enable and write-first
    access("t4_idle_after_read", 1'b0, 1'b0, 511, '0);
    access("t4_wr_rd_same",      1'b1, 1'b1, 7,   32'h12345678);
    access("t4_rd7",             1'b0, 1'b1, 7,   '0);
    access("t4_idle_wr",         1'b1, 1'b0, 8,   32'h0BADC0DE);
    access("t4_rd8",             1'b0, 1'b1, 8,   '0);

    // 5. Reset mid-operation
    access("t5_wr3",  1'b1, 1'b0, 3, 32'hFFFFFFFF);
    access("t5_rd3",  1'b0, 1'b1, 3, '0);
    bus.MWR = 1'b1;
    bus.MOE = 1'b1;
    bus.Adr = 3;
    bus.MWD = 32'h13572468;
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    check_eq("t5_async_clear", bus.MRD, 32'h0);
    @(posedge clk);
    #1;
    check_eq("t5_held_in_reset", bus.MRD, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.MWR = 1'b0;
    bus.MOE = 1'b0;
    @(posedge clk);
    #1;
    access("t5_rd3_after", 1'b0, 1'b1, 3,   '0);
    access("t5_rd7_after", 1'b0, 1'b1, 7,   '0);
    access("t5_rd511_after", 1'b0, 1'b1, 511, '0);

    // 6. Back-to-back alternating write/read over random addresses
    last_a = '0;
    for (int i = 0; i < 200; i++) begin
      a = ADDR_W'($urandom_range(0, DEPTH-1));
      d = $urandom;
      access("t6_wr", 1'b1, 1'b0, a, d);
      if ($urandom_range(0, 1) == 0) a = ADDR_W'($urandom_range(0, DEPTH-1));
      else if ($urandom_range(0, 1) == 0) a = last_a;
      access("t6_rd", 1'b0, 1'b1, a, '0);
      last_a = a;
    end

    // Random mix of all four enable combinations, small address window to
    // force frequent reuse.
    for (int i = 0; i < 400; i++) begin
      logic we;
      logic oe;
      we = 1'($urandom_range(0, 1));
      oe = 1'($urandom_range(0, 1));
      a  = ADDR_W'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) a = ADDR_W'(DEPTH - 1 - $urandom_range(0, 3));
      d  = $urandom;
      access("t6_mix", we, oe, a, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Bound on total run time in case anything stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000ns");
    $fatal(1);
  end

endmodule
